// File: rtl/drext.sv
`default_nettype none
// ============================================================================
//  Module   : drext
//  Purpose  : Load-data extraction and extension for the MEM stage. Picks the
//             addressed byte or halfword out of a 32-bit little-endian word
//             and zero- or sign-extends it to 32 bits for writeback/bypass.
//             A word access passes the data straight through. A side flag
//             reports accesses that are not naturally aligned for their size.
//             The flag is informational only and never changes the data.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    OUT_REG    0 = purely combinational result (clk/rst unused)
//               1 = result and flag registered, one cycle of latency
//  Ports
//    clk        clock, only used when OUT_REG=1
//    rst        asynchronous active-low reset, only used when OUT_REG=1
//    in_data    raw 32-bit word from memory or the bridge
//    low_addr   effective address bits [1:0]
//    exsign     1 = sign-extend, 0 = zero-extend
//    isByte     byte access (takes priority over isHalf)
//    isHalf     halfword access
//    out_data   extracted and extended load data
//    misaligned access not naturally aligned for its size
// ============================================================================
module drext #(
    parameter int OUT_REG = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic [1:0]  low_addr,
    input  logic        exsign,
    input  logic        isByte,
    input  logic        isHalf,
    output logic [31:0] out_data,
    output logic        misaligned
);

    localparam logic [31:0] c_ZERO_WORD = 32'h0000_0000;
    localparam logic [1:0]  c_ADDR_LANE0 = 2'd0;
    localparam logic [1:0]  c_ADDR_LANE1 = 2'd1;
    localparam logic [1:0]  c_ADDR_LANE2 = 2'd2;
    localparam logic [1:0]  c_ADDR_LANE3 = 2'd3;

    // ------------------------------------------------------------------
    // Size decode. isByte wins over isHalf, so isByte=isHalf=1 is simply
    // a byte access; the three access kinds are mutually exclusive.
    // ------------------------------------------------------------------
    logic w_acc_byte;
    logic w_acc_half;
    logic w_acc_word;

    assign w_acc_byte = isByte;
    assign w_acc_half = ~isByte & isHalf;
    assign w_acc_word = ~isByte & ~isHalf;

    // ------------------------------------------------------------------
    // Byte lane select: lane k is in_data[8k+7:8k].
    // ------------------------------------------------------------------
    logic [7:0] w_byte_sel;

    always_comb begin
        w_byte_sel = in_data[7:0];
        case (low_addr)
            c_ADDR_LANE0: w_byte_sel = in_data[7:0];
            c_ADDR_LANE1: w_byte_sel = in_data[15:8];
            c_ADDR_LANE2: w_byte_sel = in_data[23:16];
            c_ADDR_LANE3: w_byte_sel = in_data[31:24];
            default:      w_byte_sel = in_data[7:0];
        endcase
    end

    // ------------------------------------------------------------------
    // Halfword lane select: only low_addr[1] picks the lane. A set
    // low_addr[0] is reported as misaligned but still reads the lane
    // chosen by bit 1, so the data path never sees an odd halfword.
    // ------------------------------------------------------------------
    logic [15:0] w_half_sel;

    assign w_half_sel = low_addr[1] ? in_data[31:16] : in_data[15:0];

    // ------------------------------------------------------------------
    // Extension. The fill bit is the selected MSB gated by exsign.
    // ------------------------------------------------------------------
    logic        w_byte_fill;
    logic        w_half_fill;
    logic [31:0] w_byte_ext;
    logic [31:0] w_half_ext;

    assign w_byte_fill = exsign & w_byte_sel[7];
    assign w_half_fill = exsign & w_half_sel[15];
    assign w_byte_ext  = {{24{w_byte_fill}}, w_byte_sel};
    assign w_half_ext  = {{16{w_half_fill}}, w_half_sel};

    // ------------------------------------------------------------------
    // Result mux and alignment flag.
    // ------------------------------------------------------------------
    logic [31:0] w_data;
    logic        w_mis;

    always_comb begin
        w_data = in_data;
        if (w_acc_byte) begin
            w_data = w_byte_ext;
        end else if (w_acc_half) begin
            w_data = w_half_ext;
        end else begin
            w_data = in_data;
        end
    end

    always_comb begin
        w_mis = 1'b0;
        if (w_acc_half) begin
            w_mis = low_addr[0];
        end else if (w_acc_word) begin
            w_mis = (low_addr != c_ADDR_LANE0);
        end else begin
            w_mis = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Output stage.
    // ------------------------------------------------------------------
    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [31:0] r_data;
            logic        r_mis;

            // Captured every cycle with no enable; reset clears the
            // outputs asynchronously so a flushed load never leaks stale
            // data onto the bypass network.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_data <= c_ZERO_WORD;
                    r_mis  <= 1'b0;
                end else begin
                    r_data <= w_data;
                    r_mis  <= w_mis;
                end
            end

            assign out_data   = r_data;
            assign misaligned = r_mis;
        end else begin : g_out_comb
            // Clock and reset have no function in the combinational build.
            logic w_unused_clk_rst;
            assign w_unused_clk_rst = clk ^ rst;

            assign out_data   = w_data;
            assign misaligned = w_mis;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_drext.sv
`default_nettype none
// ============================================================================
//  Module   : tb_drext
//  Purpose  : Self-checking bench for drext. One combinational instance
//             (OUT_REG=0) and one registered instance (OUT_REG=1) share the
//             same stimulus. Expected values are pushed to a scoreboard
//             queue when stimulus is applied and popped when the output is
//             sampled.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_drext;

    typedef struct packed {
        logic [31:0] data;
        logic        mis;
    } exp_t;

    logic        clk;
    logic        clk_en;
    logic        rst;
    logic [31:0] in_data;
    logic [1:0]  low_addr;
    logic        exsign;
    logic        isByte;
    logic        isHalf;
    logic [31:0] c_out_data;
    logic        c_misaligned;
    logic [31:0] r_out_data;
    logic        r_misaligned;

    int total;
    int bad;

    exp_t sb[$];

    drext #(.OUT_REG(0)) u_comb (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .low_addr   (low_addr),
        .exsign     (exsign),
        .isByte     (isByte),
        .isHalf     (isHalf),
        .out_data   (c_out_data),
        .misaligned (c_misaligned)
    );

    drext #(.OUT_REG(1)) u_reg (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .low_addr   (low_addr),
        .exsign     (exsign),
        .isByte     (isByte),
        .isHalf     (isHalf),
        .out_data   (r_out_data),
        .misaligned (r_misaligned)
    );

    // Gated clock so the reset test can show the flop output with no edges.
    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    // Drive one access and record what it must produce.
    task automatic apply(input logic [31:0] d, input logic [1:0] a, input logic s,
                         input logic b, input logic h,
                         input logic [31:0] exp_d, input logic exp_m);
        exp_t e;
        in_data  = d;
        low_addr = a;
        exsign   = s;
        isByte   = b;
        isHalf   = h;
        e.data   = exp_d;
        e.mis    = exp_m;
        sb.push_back(e);
    endtask

    task automatic test_reset;
        exp_t e;
        clk_en = 1'b0;
        rst    = 1'b0;
        apply(32'h8070_F0A5, 2'd3, 1'b1, 1'b1, 1'b0, 32'hFFFF_FF80, 1'b0);
        #3;
        e = sb.pop_front();
        total++;
        if (r_out_data !== 32'h0 || r_misaligned !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold_reg: got data=%h mis=%b want data=00000000 mis=0", r_out_data, r_misaligned);
        end
        total++;
        if (c_out_data !== e.data || c_misaligned !== e.mis) begin
            bad++;
            $display("FAIL reset_comb_ignores_rst: got data=%h mis=%b want data=%h mis=%b", c_out_data, c_misaligned, e.data, e.mis);
        end
    endtask

    task automatic test_byte;
        exp_t e;
        logic [31:0] vd[8];
        logic [1:0]  va[8];
        logic        vs[8];
        logic [31:0] vx[8];
        vd = '{32'h8070_F0A5, 32'h8070_F0A5, 32'h8070_F0A5, 32'h8070_F0A5,
               32'h8070_F0A5, 32'h8070_F0A5, 32'h8070_F0A5, 32'h7F00_017F};
        va = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd3, 2'd0};
        vs = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vx = '{32'hFFFF_FFA5, 32'hFFFF_FFF0, 32'h0000_0070, 32'hFFFF_FF80,
               32'h0000_00A5, 32'h0000_00F0, 32'h0000_0080, 32'h0000_007F};
        for (int i = 0; i < 8; i++) begin
            apply(vd[i], va[i], vs[i], 1'b1, 1'b0, vx[i], 1'b0);
            #1;
            e = sb.pop_front();
            total++;
            if (c_out_data !== e.data || c_misaligned !== e.mis) begin
                bad++;
                $display("FAIL byte[%0d]: got data=%h mis=%b want data=%h mis=%b", i, c_out_data, c_misaligned, e.data, e.mis);
            end
        end
    endtask

    task automatic test_half;
        exp_t e;
        logic [1:0]  va[6];
        logic        vs[6];
        logic [31:0] vx[6];
        logic        vm[6];
        va = '{2'd0, 2'd2, 2'd2, 2'd3, 2'd1, 2'd0};
        vs = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vx = '{32'hFFFF_F0A5, 32'hFFFF_8070, 32'h0000_8070, 32'hFFFF_8070,
               32'h0000_F0A5, 32'h0000_F0A5};
        vm = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            apply(32'h8070_F0A5, va[i], vs[i], 1'b0, 1'b1, vx[i], vm[i]);
            #1;
            e = sb.pop_front();
            total++;
            if (c_out_data !== e.data || c_misaligned !== e.mis) begin
                bad++;
                $display("FAIL half[%0d]: got data=%h mis=%b want data=%h mis=%b", i, c_out_data, c_misaligned, e.data, e.mis);
            end
        end
    endtask

    task automatic test_word;
        exp_t e;
        for (int a = 0; a < 4; a++) begin
            apply(32'h8070_F0A5, 2'(a), a[0], 1'b0, 1'b0, 32'h8070_F0A5, (a != 0));
            #1;
            e = sb.pop_front();
            total++;
            if (c_out_data !== e.data || c_misaligned !== e.mis) begin
                bad++;
                $display("FAIL word[%0d]: got data=%h mis=%b want data=%h mis=%b", a, c_out_data, c_misaligned, e.data, e.mis);
            end
        end
    endtask

    task automatic test_priority;
        exp_t e;
        apply(32'h8070_F0A5, 2'd1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF0, 1'b0);
        #1;
        e = sb.pop_front();
        total++;
        if (c_out_data !== e.data || c_misaligned !== e.mis) begin
            bad++;
            $display("FAIL priority: got data=%h mis=%b want data=%h mis=%b", c_out_data, c_misaligned, e.data, e.mis);
        end
    endtask

    // Registered instance: release reset, then one new access per cycle.
    task automatic test_back_to_back;
        exp_t e;
        clk_en = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        apply(32'h8070_F0A5, 2'd3, 1'b1, 1'b1, 1'b0, 32'hFFFF_FF80, 1'b0);
        #1;
        total++;
        if (r_out_data !== 32'h0) begin
            bad++;
            $display("FAIL reg_not_before_edge: got data=%h want data=00000000", r_out_data);
        end
        @(posedge clk);
        #1;
        e = sb.pop_front();
        total++;
        if (r_out_data !== e.data || r_misaligned !== e.mis) begin
            bad++;
            $display("FAIL reg_first_capture: got data=%h mis=%b want data=%h mis=%b", r_out_data, r_misaligned, e.data, e.mis);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            case (i)
                0: apply(32'h8070_F0A5, 2'd3, 1'b1, 1'b0, 1'b1, 32'hFFFF_8070, 1'b1);
                1: apply(32'h8070_F0A5, 2'd2, 1'b0, 1'b0, 1'b0, 32'h8070_F0A5, 1'b1);
                2: apply(32'h1234_5678, 2'd1, 1'b0, 1'b1, 1'b0, 32'h0000_0056, 1'b0);
                default: apply(32'hCAFE_8001, 2'd0, 1'b1, 1'b0, 1'b1, 32'hFFFF_8001, 1'b0);
            endcase
            @(posedge clk);
            #1;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL reg_b2b[%0d]: scoreboard empty got data=%h want an entry", i, r_out_data);
            end else begin
                e = sb.pop_front();
                if (r_out_data !== e.data || r_misaligned !== e.mis) begin
                    bad++;
                    $display("FAIL reg_b2b[%0d]: got data=%h mis=%b want data=%h mis=%b", i, r_out_data, r_misaligned, e.data, e.mis);
                end
            end
        end
    endtask

    task automatic test_async_reset;
        exp_t e;
        // Output currently holds a nonzero, misaligned-flagged value.
        @(negedge clk);
        apply(32'h8070_F0A5, 2'd1, 1'b1, 1'b0, 1'b1, 32'hFFFF_F0A5, 1'b1);
        @(posedge clk);
        #2;
        e = sb.pop_front();
        total++;
        if (r_out_data !== e.data || r_misaligned !== e.mis) begin
            bad++;
            $display("FAIL reg_pre_reset: got data=%h mis=%b want data=%h mis=%b", r_out_data, r_misaligned, e.data, e.mis);
        end
        rst = 1'b0;
        #1;
        total++;
        if (r_out_data !== 32'h0 || r_misaligned !== 1'b0) begin
            bad++;
            $display("FAIL reg_async_clear: got data=%h mis=%b want data=00000000 mis=0", r_out_data, r_misaligned);
        end
        @(posedge clk);
        #1;
        total++;
        if (r_out_data !== 32'h0 || r_misaligned !== 1'b0) begin
            bad++;
            $display("FAIL reg_held_in_reset: got data=%h mis=%b want data=00000000 mis=0", r_out_data, r_misaligned);
        end
        @(negedge clk);
        rst = 1'b1;
        apply(32'h8070_F0A5, 2'd0, 1'b0, 1'b1, 1'b0, 32'h0000_00A5, 1'b0);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        total++;
        if (r_out_data !== e.data || r_misaligned !== e.mis) begin
            bad++;
            $display("FAIL reg_resume: got data=%h mis=%b want data=%h mis=%b", r_out_data, r_misaligned, e.data, e.mis);
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        clk_en   = 1'b0;
        rst      = 1'b0;
        in_data  = 32'h0;
        low_addr = 2'd0;
        exsign   = 1'b0;
        isByte   = 1'b0;
        isHalf   = 1'b0;
        #1;
        test_reset();
        test_byte();
        test_half();
        test_word();
        test_priority();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
